// File: rtl/row_sync_arbiter.sv
// ----------------------------------------------------------------------------
// row_sync_arbiter
//
// Round-robin arbiter and round barrier for the cores of one row. Exactly one
// core at a time owns the shared row buffer. After each grant the arbiter
// waits for the URAM drain to report the buffer empty before it scans again.
// Once every core has been served in the current round, a one-cycle
// round-done pulse is produced.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a grant that lasts TIMEOUT_CYCLES cycles is revoked. The core
//   is then blocked until it drops its request for at least one cycle.
//   When undefined, a grant is held for as long as the request stays high,
//   and o_timeout is tied low.
//
// Ports:
//   clk             system clock, same domain as the cores
//   reset           asynchronous active-low reset
//   i_core_req      per-core request level (bit k = core k)
//   o_core_grant    one-hot-or-zero grant vector (registered)
//   o_grant_valid   high while any grant bit is high (registered)
//   o_grant_idx     index of the granted core; keeps its last value when idle
//   i_uram_emptied  level from the drain logic, high when the buffer is empty
//   o_round_done    one-cycle pulse when every core has been served
//   o_timeout       one-cycle pulse on forced revocation (0 without the macro)
// ----------------------------------------------------------------------------
module row_sync_arbiter #(
    parameter int NUM_CORES      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CORES-1:0]         i_core_req,
    output logic [NUM_CORES-1:0]         o_core_grant,
    output logic                         o_grant_valid,
    output logic [$clog2(NUM_CORES)-1:0] o_grant_idx,
    input  logic                         i_uram_emptied,
    output logic                         o_round_done,
    output logic                         o_timeout
);

    localparam int IDX_W = $clog2(NUM_CORES);

    // Core count at one extra bit of width, for the modulo wrap in the scan.
    localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_CORES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAIN
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_CORES-1:0] served;

    logic [NUM_CORES-1:0] eligible;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W:0]       cand;
    logic                 req_gone;
    logic                 timeout_hit;
    logic                 end_grant;
    logic [NUM_CORES-1:0] served_next;
    logic [IDX_W-1:0]     rr_next;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]     grant_cnt;
    logic [NUM_CORES-1:0] blocked;

    // A core that timed out is skipped until it has dropped its request.
    assign eligible    = i_core_req & ~blocked;
    assign timeout_hit = (grant_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign eligible    = i_core_req;
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    // Round-robin scan: first eligible core at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!pick_found && eligible[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // The grant ends when the owner drops its request or the timeout fires;
    // a normal release wins over a timeout landing on the same edge.
    assign req_gone    = !i_core_req[o_grant_idx];
    assign end_grant   = (state == GRANT) && (req_gone || timeout_hit);

    // o_core_grant is the one-hot of the current owner, so it doubles as the
    // served-bit to merge in at release.
    assign served_next = served | o_core_grant;
    assign rr_next     = (o_grant_idx == LAST_IDX) ? '0 : o_grant_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            served        <= '0;
            o_core_grant  <= '0;
            o_grant_valid <= 1'b0;
            o_grant_idx   <= '0;
            o_round_done  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            o_round_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        o_core_grant  <= NUM_CORES'(1) << pick_idx;
                        o_grant_valid <= 1'b1;
                        o_grant_idx   <= pick_idx;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    if (end_grant) begin
                        o_core_grant  <= '0;
                        o_grant_valid <= 1'b0;
                        rr_ptr        <= rr_next;
                        state         <= DRAIN;
                        // Barrier fires on the release that completes the set;
                        // repeat service only re-sets an already-set bit.
                        if (&served_next) begin
                            served       <= '0;
                            o_round_done <= 1'b1;
                        end else begin
                            served <= served_next;
                        end
                    end
                end
                DRAIN: begin
                    if (i_uram_emptied) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
            blocked   <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            // Entering GRANT starts at 1 so the count equals the number of
            // cycles the grant has been visible.
            if (state == IDLE && pick_found) begin
                grant_cnt <= CNT_W'(1);
            end else if (state == GRANT && !end_grant) begin
                grant_cnt <= grant_cnt + 1'b1;
            end

            if (state == GRANT && !req_gone && timeout_hit) begin
                o_timeout <= 1'b1;
                blocked   <= (blocked & i_core_req) | o_core_grant;
            end else begin
                blocked   <= blocked & i_core_req;
            end
        end
    end
`endif

endmodule

// File: doc/row_sync_arbiter.md
# row_sync_arbiter

Row-level arbiter and barrier that answers the per-core `o_core_req` / `i_core_grant` handshake of every core top in one row. It grants exclusive access to the shared row buffer to one core at a time, in round-robin order. Between grants it waits for the downstream URAM drain to report empty. It pulses a round-done barrier once every core in the row has been served.

## Interface
Parameters:
- `NUM_CORES`, 8: requesters in the row; ≥2, power of two not required.
- `TIMEOUT_CYCLES`, 1024: maximum consecutive grant cycles. Used only with `ARB_TIMEOUT_EN`; ≥2.

Ports:
- `clk`  in  1  system clock, same domain as the cores.
- `reset`  in  1  asynchronous, active-low reset.
- `i_core_req`  in  NUM_CORES  per-core request; bit k is core k's `o_core_req`.
- `o_core_grant`  out  NUM_CORES  one-hot-or-zero grant; bit k drives core k's `i_core_grant`.
- `o_grant_valid`  out  1  high while any grant bit is high.
- `o_grant_idx`  out  $clog2(NUM_CORES)  index of the granted core; holds the last value when idle.
- `i_uram_emptied`  in  1  level from the drain logic; high when the shared buffer is empty.
- `o_round_done`  out  1  one-cycle pulse when all cores have been served in the current round.
- `o_timeout`  out  1  one-cycle pulse on forced grant revocation; tied 0 without the macro.

## Operation
- The FSM has three states: IDLE, GRANT, DRAIN.
- **IDLE:** scan `i_core_req` starting from `rr_ptr` and wrapping modulo NUM_CORES. The first set bit k that is not blocked wins. Load `o_core_grant = 1<<k`, `o_grant_idx = k`, and go to GRANT. If no bit qualifies, stay in IDLE.
- **GRANT:** hold the grant while `i_core_req[k]` = 1. When `i_core_req[k]` = 0:
  - clear the grant;
  - set `served[k]`;
  - set `rr_ptr = (k+1) mod NUM_CORES`;
  - go to DRAIN.
- **DRAIN:** when `i_uram_emptied` = 1, go to IDLE. Otherwise stay in DRAIN with no grant.
- **Round barrier:**
  - When the update of `served[k]` makes `served` all-ones, pulse `o_round_done` on the cycle the FSM enters DRAIN.
  - On that same edge, `served` clears to 0.
  - Repeat service of a core within a round is allowed and does not re-trigger the barrier.
- **Request changes outside GRANT:** requests that rise and fall while the FSM is in DRAIN or IDLE-with-gap are not latched. The arbiter is level-sensitive only.
- **Reset asserted:** all state clears immediately, including mid-GRANT or mid-DRAIN.
  - `o_core_grant` = 0, `o_grant_valid` = 0, `o_grant_idx` = 0, `o_round_done` = 0, `o_timeout` = 0.
  - `rr_ptr` = 0, `served` = 0, state = IDLE.
- **After reset releases:** the first legal grant is core 0 if it is requesting.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Grant latency:** a request seen in IDLE at edge n produces `o_core_grant` high after edge n.
- **Release:** `i_core_req[k]` low sampled at edge m gives grant low after edge m and the state DRAIN.
- **Minimum gap:** there is at least one DRAIN cycle between two grants, even if `i_uram_emptied` is already high. The minimum grant-to-grant gap is 2 cycles: one DRAIN cycle and one IDLE scan.
- **Simultaneous requests:** round-robin from `rr_ptr` decides. Example: `rr_ptr`=3 with requests on bits {1,5} grants core 5.
- `o_round_done` and `o_timeout` are exactly one cycle wide and may coincide.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts grant cycles.
  - When the counter reaches TIMEOUT_CYCLES while the request is still high: revoke the grant, pulse `o_timeout`, treat core k as served, advance `rr_ptr`, go to DRAIN, and set `blocked[k]`.
  - `blocked[k]` clears when `i_core_req[k]` is sampled low. A blocked core is skipped in IDLE.
- **Undefined:** there is no counter and no `blocked` mask; `o_timeout` = 0 constant. A grant is held indefinitely.

## Test plan
- **Reset mid-grant:** with core 2 granted, assert `reset` low asynchronously → all outputs are 0 before the next edge. After release, core 0 and core 2 requesting → core 0 is granted first.
- **Round-robin fairness:** NUM_CORES=8 with all requests held high and each grant held 3 cycles. `i_uram_emptied`=1 gives grant order 0,1,…,7,0. `o_round_done` pulses exactly once, on the cycle after core 7 releases.
- **Drain wait:** core 4 releases while `i_uram_emptied`=0 for 10 cycles, with core 5 requesting. No grant appears until 2 cycles after `i_uram_emptied` rises.
- **Priority wrap:** `rr_ptr`=6 with requests {1,3} → core 1 is granted, then core 3.
- **Timeout (`ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=16):** core 0 holds its request indefinitely. The grant drops after 16 grant cycles and `o_timeout` pulses once. Core 0 is not regranted until its request drops for ≥1 cycle, while core 1 requesting is granted next.
- **Without `ARB_TIMEOUT_EN`:** same stimulus → core 0 keeps the grant for 1000 cycles and `o_timeout` stays 0.
